// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART TX FIFO write port
// between NREQ byte streams; the grant is held for a whole packet, capped at MAX_LEN bytes.
module uart_tx_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned DBIT    = 8,
  parameter int unsigned MAX_LEN = 255,
  parameter int unsigned LEN_BIT = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*DBIT-1:0] req_data,
  input  logic [NREQ-1:0]      req_last,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 tx_full,
  output logic                 wr_uart,
  output logic [DBIT-1:0]      w_data,
  output logic [NREQ-1:0]      grant,
  output logic                 busy,
  output logic                 trunc_tick
);

  localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t             state_q, state_d;
  logic [NREQ-1:0]    grant_q, grant_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [LEN_BIT-1:0] count_q, count_d;
  logic               trunc_q, trunc_d;

  logic [NREQ-1:0]    pick_oh;
  logic               pick_any;
  logic [PTR_W-1:0]   pick_idx;
  logic [PTR_W-1:0]   owner_idx;
  logic [PTR_W-1:0]   owner_next;
  logic [DBIT-1:0]    owner_data;
  logic               owner_valid;
  logic               owner_last;
  logic               xfer;

  // First valid requester scanning from rr_ptr upward, wrapping at NREQ.
  always_comb begin
    pick_oh  = '0;
    pick_any = 1'b0;
    pick_idx = '0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      pick_idx = PTR_W'((32'(rr_ptr_q) + off) % NREQ);
      if (!pick_any && req_valid[pick_idx]) begin
        pick_oh[pick_idx] = 1'b1;
        pick_any          = 1'b1;
      end
    end
  end

  always_comb begin
    owner_idx  = '0;
    owner_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_q[i]) begin
        owner_idx  = PTR_W'(i);
        owner_data = req_data[i*DBIT +: DBIT];
      end
    end
  end

  assign owner_valid = |(req_valid & grant_q);
  assign owner_last  = |(req_last & grant_q);
  assign owner_next  = (32'(owner_idx) == NREQ - 1) ? '0 : owner_idx + PTR_W'(1);
  assign xfer        = (state_q == SEND) && owner_valid && !tx_full;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    count_d   = count_q;
    trunc_d   = 1'b0;
    wr_uart   = 1'b0;
    req_ready = '0;
    w_data    = '0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d = pick_oh;
          count_d = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        wr_uart   = xfer;
        req_ready = xfer ? grant_q : '0;
        w_data    = owner_data;
        if (xfer) begin
          // A last byte landing on the cap is a normal release, not a truncation.
          if (owner_last || (count_q == LEN_BIT'(MAX_LEN - 1))) begin
            state_d  = IDLE;
            grant_d  = '0;
            rr_ptr_d = owner_next;
            count_d  = '0;
            trunc_d  = !owner_last;
          end else begin
            count_d = count_q + LEN_BIT'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      count_q  <= '0;
      trunc_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      count_q  <= count_d;
      trunc_q  <= trunc_d;
    end
  end

  assign grant      = grant_q;
  assign busy       = (state_q == SEND);
  assign trunc_tick = trunc_q;

endmodule
